// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, imem address, IF/ID pipeline register, HLT detection.
// Latency: instruction at pc lands in IF/ID one edge later; a redirect costs exactly one bubble.
// Backpressure: stall freezes pc, IF/ID and state; branch_taken overrides stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       hold request from decode
//   branch_taken/branch_target  redirect from branch control (target bit 0 ignored)
//   imem_addr/imem_data         instruction-memory address (== pc) and same-cycle data
//   pc_curr                     current pc register
//   if_id_instr/_pc_plus2/_valid  IF/ID pipeline register
//   halted                      HLT fetched, fetch stopped until reset
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_curr,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] instr_nxt;
    logic [15:0] pp2_nxt;
    logic        valid_nxt;
    logic [15:0] pc_plus2;
    logic        is_hlt;

    // Wraps modulo 2^16; no carry out.
    assign pc_plus2 = pc + 16'd2;
    assign is_hlt   = (imem_data[15:12] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_instr    <= 16'h0000;
            if_id_pc_plus2 <= 16'h0000;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc_plus2 <= pp2_nxt;
            if_id_valid    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pp2_nxt   = if_id_pc_plus2;
        valid_nxt = if_id_valid;

        if (branch_taken) begin
            // Redirect squashes whatever is being fetched, including an HLT.
            pc_nxt    = branch_target & 16'hFFFE;
            instr_nxt = 16'h0000;
            pp2_nxt   = 16'h0000;
            valid_nxt = 1'b0;
        end else if (stall) begin
            // Hold everything.
        end else if (state == HALTED) begin
            instr_nxt = 16'h0000;
            valid_nxt = 1'b0;
        end else begin
            instr_nxt = imem_data;
            pp2_nxt   = pc_plus2;
            valid_nxt = 1'b1;
            if (is_hlt) begin
                // HLT is delivered downstream but pc parks on its address.
                state_nxt = HALTED;
            end else begin
                pc_nxt = pc_plus2;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_curr   = pc;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc_curr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc_curr        (pc_curr),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    // Reference model: architectural view of the fetch stage.
    logic [15:0] m_pc, m_instr, m_pp2;
    logic        m_valid, m_halted;

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return {4'h1, a[11:0]};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] word;
        word = mem[m_pc];
        if (b) begin
            m_pc = {t[15:1], 1'b0};
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else if (s) begin
            // frozen
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_pp2   = m_pc + 16'd2;
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pc"},        pc_curr, 16'h0000);
        chk({tag, " imem_addr"}, imem_addr, 16'h0000);
        chk({tag, " instr"},     if_id_instr, 16'h0000);
        chk({tag, " pp2"},       if_id_pc_plus2, 16'h0000);
        chk({tag, " valid"},     {15'd0, if_id_valid}, 16'd0);
        chk({tag, " halted"},    {15'd0, halted}, 16'd0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " pc"},     pc_curr, m_pc);
        chk({tag, " addr"},   imem_addr, m_pc);
        chk({tag, " instr"},  if_id_instr, m_instr);
        chk({tag, " valid"},  {15'd0, if_id_valid}, {15'd0, m_valid});
        chk({tag, " halted"}, {15'd0, halted}, {15'd0, m_halted});
        // pc_plus2 is only meaningful outside the post-halt bubble stream.
        if (m_valid || !m_halted) chk({tag, " pp2"}, if_id_pc_plus2, m_pp2);
    endtask

    // Inputs change just after a falling edge; outputs are read on the next falling edge.
    task automatic step(input logic s, input logic b, input logic [15:0] t);
        stall = s; branch_taken = b; branch_target = t;
        model_edge(s, b, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic        b;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t tbl [18];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = mem_default(16'(i));
        mem[16'h0020] = 16'hF000;

        //          s  b  tgt       pc        instr     pp2       v  h
        tbl[0]  = '{0, 0, 16'h0000, 16'h0002, 16'h1000, 16'h0002, 1, 0};
        tbl[1]  = '{0, 0, 16'h0000, 16'h0004, 16'h1002, 16'h0004, 1, 0};
        tbl[2]  = '{0, 1, 16'h0011, 16'h0010, 16'h0000, 16'h0000, 0, 0};
        tbl[3]  = '{0, 1, 16'h0041, 16'h0040, 16'h0000, 16'h0000, 0, 0};
        tbl[4]  = '{0, 0, 16'h0000, 16'h0042, 16'h1040, 16'h0042, 1, 0};
        tbl[5]  = '{0, 1, 16'h0009, 16'h0008, 16'h0000, 16'h0000, 0, 0};
        tbl[6]  = '{1, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0};
        tbl[7]  = '{1, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0};
        tbl[8]  = '{1, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0};
        tbl[9]  = '{0, 0, 16'h0000, 16'h000A, 16'h1008, 16'h000A, 1, 0};
        tbl[10] = '{0, 0, 16'h0000, 16'h000C, 16'h100A, 16'h000C, 1, 0};
        tbl[11] = '{1, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 0, 0};
        tbl[12] = '{0, 1, 16'h0030, 16'h0030, 16'h0000, 16'h0000, 0, 0};
        tbl[13] = '{0, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 0, 0};
        tbl[14] = '{0, 0, 16'h0000, 16'h0020, 16'hF000, 16'h0022, 1, 1};
        tbl[15] = '{0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0022, 0, 1};
        tbl[16] = '{1, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0022, 0, 1};
        tbl[17] = '{0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0022, 0, 1};

        // Reset state while held.
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].s, tbl[i].b, tbl[i].tgt);
            chk($sformatf("tbl%0d pc", i),     pc_curr, tbl[i].pc);
            chk($sformatf("tbl%0d addr", i),   imem_addr, tbl[i].pc);
            chk($sformatf("tbl%0d instr", i),  if_id_instr, tbl[i].instr);
            chk($sformatf("tbl%0d valid", i),  {15'd0, if_id_valid}, {15'd0, tbl[i].valid});
            chk($sformatf("tbl%0d halted", i), {15'd0, halted}, {15'd0, tbl[i].halted});
            if (tbl[i].valid || !tbl[i].halted)
                chk($sformatf("tbl%0d pp2", i), if_id_pc_plus2, tbl[i].pp2);
        end

        // Asynchronous reset mid-cycle while HALTED.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async_halted");
        mem[16'h0020] = mem_default(16'h0020);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch at the first edge after release.
        step(0, 0, 16'h0000);
        chk("rel pc", pc_curr, 16'h0002);
        chk("rel valid", {15'd0, if_id_valid}, 16'd1);
        chk("rel instr", if_id_instr, 16'h1000);

        // PC wrap at 16'hFFFE.
        step(0, 1, 16'hFFFF);
        chk("wrap tgt pc", pc_curr, 16'hFFFE);
        step(0, 0, 16'h0000);
        chk("wrap pc", pc_curr, 16'h0000);
        chk("wrap pp2", if_id_pc_plus2, 16'h0000);
        chk("wrap instr", if_id_instr, 16'h1FFE);

        // Asynchronous reset mid-stall.
        step(1, 0, 16'h0000);
        step(1, 0, 16'h0000);
        chk("stall hold pc", pc_curr, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_stall");
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 8; ep++) begin
            logic [15:0] h;
            h = 16'($urandom_range(8, 63) * 2);
            mem[h] = 16'hF000 | 16'($urandom_range(0, 4095));
            sync_reset();
            for (int c = 0; c < 150; c++) begin
                logic s, b;
                logic [15:0] t;
                s = ($urandom_range(0, 3) == 0);
                b = ($urandom_range(0, 7) == 0);
                t = 16'($urandom_range(0, 255));
                step(s, b, t);
                chk_model($sformatf("rnd%0d.%0d", ep, c));
            end
            mem[h] = mem_default(h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
